// File: rtl/local_ni.sv
// Router LOCAL-port network interface: buffers and serializes core flits onto the router link,
// deserializes router frames for the core, and counts completed transfers in both directions.
module local_ni #(
  parameter int ROUTER_ID    = -1,
  parameter int ADDR_BITS    = 4,
  parameter int PAYLOAD_SIZE = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inj_valid,
  output logic                    inj_ready,
  input  logic [ADDR_BITS-1:0]    inj_dest,
  input  logic [PAYLOAD_SIZE-1:0] inj_payload,
  output logic                    ser_out,
  input  logic                    ser_busy,
  input  logic                    ser_in,
  output logic                    ser_in_busy,
  output logic                    ej_valid,
  input  logic                    ej_ready,
  output logic [ADDR_BITS-1:0]    ej_dest,
  output logic [PAYLOAD_SIZE-1:0] ej_payload,
  output logic [15:0]             sent_count,
  output logic [15:0]             recv_count
);

  localparam int FLIT_W = PAYLOAD_SIZE + ADDR_BITS;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = $clog2(FLIT_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(FLIT_W - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   PTR_ONE  = {{AW{1'b0}}, 1'b1};

  // ROUTER_ID only tags simulation messages; it has no hardware effect.
  if (ROUTER_ID < 0) begin : g_unattached
  end else begin : g_attached
  end

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_LOAD = 2'd1,
    TX_DATA = 2'd2,
    TX_GAP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_RECV = 2'd1,
    RX_HOLD = 2'd2
  } rx_state_t;

  logic [FLIT_W-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_r;
  logic [AW:0]       rd_ptr_r;
  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic              push_s;
  logic              pop_s;

  tx_state_t         tx_state_r;
  logic [FLIT_W-1:0] tx_shift_r;
  logic [CW-1:0]     tx_cnt_r;
  logic              ser_out_r;
  logic [15:0]       sent_count_r;

  rx_state_t         rx_state_r;
  logic [FLIT_W-2:0] rx_shift_r;
  logic [CW-1:0]     rx_cnt_r;
  logic              ser_in_busy_r;
  logic              ej_valid_r;
  logic [ADDR_BITS-1:0]    ej_dest_r;
  logic [PAYLOAD_SIZE-1:0] ej_payload_r;
  logic [15:0]       recv_count_r;

  assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
  assign fifo_full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                        (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign push_s       = inj_valid && !fifo_full_s;
  // A new frame may be launched from IDLE or straight out of the gap cycle,
  // which is what keeps back-to-back frames exactly one idle cycle apart.
  assign pop_s        = ((tx_state_r == TX_IDLE) || (tx_state_r == TX_GAP)) &&
                        !fifo_empty_s && !ser_busy;

  assign inj_ready   = !fifo_full_s;
  assign ser_out     = ser_out_r;
  assign sent_count  = sent_count_r;
  assign ser_in_busy = ser_in_busy_r;
  assign ej_valid    = ej_valid_r;
  assign ej_dest     = ej_dest_r;
  assign ej_payload  = ej_payload_r;
  assign recv_count  = recv_count_r;

  // Injection FIFO storage.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r[AW-1:0]] <= {inj_dest, inj_payload};
    end
  end

  // Injection FIFO pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Serializer: start bit, FLIT_W data bits LSB first, one gap cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_r   <= TX_IDLE;
      tx_shift_r   <= {FLIT_W{1'b0}};
      tx_cnt_r     <= {CW{1'b0}};
      ser_out_r    <= 1'b0;
      sent_count_r <= 16'h0000;
    end else begin
      case (tx_state_r)
        TX_IDLE: begin
          ser_out_r <= 1'b0;
          if (pop_s) begin
            tx_shift_r <= fifo_mem_r[rd_ptr_r[AW-1:0]];
            tx_state_r <= TX_LOAD;
          end
        end
        TX_LOAD: begin
          ser_out_r  <= 1'b1;
          tx_cnt_r   <= {CW{1'b0}};
          tx_state_r <= TX_DATA;
        end
        TX_DATA: begin
          ser_out_r  <= tx_shift_r[0];
          tx_shift_r <= tx_shift_r >> 1;
          tx_cnt_r   <= tx_cnt_r + CNT_ONE;
          if (tx_cnt_r == LAST_BIT) begin
            tx_state_r <= TX_GAP;
          end
        end
        TX_GAP: begin
          ser_out_r <= 1'b0;
          if (sent_count_r != 16'hFFFF) begin
            sent_count_r <= sent_count_r + 16'h0001;
          end
          if (pop_s) begin
            tx_shift_r <= fifo_mem_r[rd_ptr_r[AW-1:0]];
            tx_state_r <= TX_LOAD;
          end else begin
            tx_state_r <= TX_IDLE;
          end
        end
        default: begin
          ser_out_r  <= 1'b0;
          tx_state_r <= TX_IDLE;
        end
      endcase
    end
  end

  // Deserializer and ejection handshake; busy covers the whole frame plus the hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_r    <= RX_IDLE;
      rx_shift_r    <= {(FLIT_W-1){1'b0}};
      rx_cnt_r      <= {CW{1'b0}};
      ser_in_busy_r <= 1'b0;
      ej_valid_r    <= 1'b0;
      ej_dest_r     <= {ADDR_BITS{1'b0}};
      ej_payload_r  <= {PAYLOAD_SIZE{1'b0}};
      recv_count_r  <= 16'h0000;
    end else begin
      case (rx_state_r)
        RX_IDLE: begin
          if (ser_in) begin
            rx_cnt_r      <= {CW{1'b0}};
            ser_in_busy_r <= 1'b1;
            rx_state_r    <= RX_RECV;
          end
        end
        RX_RECV: begin
          rx_shift_r <= {ser_in, rx_shift_r[FLIT_W-2:1]};
          rx_cnt_r   <= rx_cnt_r + CNT_ONE;
          if (rx_cnt_r == LAST_BIT) begin
            {ej_dest_r, ej_payload_r} <= {ser_in, rx_shift_r};
            ej_valid_r <= 1'b1;
            rx_state_r <= RX_HOLD;
          end
        end
        RX_HOLD: begin
          if (ej_ready) begin
            ej_valid_r    <= 1'b0;
            ser_in_busy_r <= 1'b0;
            rx_state_r    <= RX_IDLE;
            if (recv_count_r != 16'hFFFF) begin
              recv_count_r <= recv_count_r + 16'h0001;
            end
          end
        end
        default: begin
          ej_valid_r    <= 1'b0;
          ser_in_busy_r <= 1'b0;
          rx_state_r    <= RX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_local_ni.sv
// Directed + randomized bench for local_ni; expected frames, fields and counters come from
// a queue/arithmetic model of the link format and transfer counting.
module tb_local_ni;

  localparam int ADDR_BITS    = 4;
  localparam int PAYLOAD_SIZE = 8;
  localparam int FIFO_DEPTH   = 4;
  localparam int FLIT_W       = ADDR_BITS + PAYLOAD_SIZE;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    inj_valid;
  logic                    inj_ready;
  logic [ADDR_BITS-1:0]    inj_dest;
  logic [PAYLOAD_SIZE-1:0] inj_payload;
  logic                    ser_out;
  logic                    ser_busy;
  logic                    ser_in;
  logic                    ser_in_busy;
  logic                    ej_valid;
  logic                    ej_ready;
  logic [ADDR_BITS-1:0]    ej_dest;
  logic [PAYLOAD_SIZE-1:0] ej_payload;
  logic [15:0]             sent_count;
  logic [15:0]             recv_count;

  int vectors     = 0;
  int miscompares = 0;
  int sent_m      = 0;
  int recv_m      = 0;
  logic [FLIT_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  local_ni #(
    .ROUTER_ID   (0),
    .ADDR_BITS   (ADDR_BITS),
    .PAYLOAD_SIZE(PAYLOAD_SIZE),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .inj_valid  (inj_valid),
    .inj_ready  (inj_ready),
    .inj_dest   (inj_dest),
    .inj_payload(inj_payload),
    .ser_out    (ser_out),
    .ser_busy   (ser_busy),
    .ser_in     (ser_in),
    .ser_in_busy(ser_in_busy),
    .ej_valid   (ej_valid),
    .ej_ready   (ej_ready),
    .ej_dest    (ej_dest),
    .ej_payload (ej_payload),
    .sent_count (sent_count),
    .recv_count (recv_count)
  );

  function automatic int sat_inc(input int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a start bit on ser_out, then collects FLIT_W bits LSB first.
  task automatic capture_frame(output logic [FLIT_W-1:0] flit, output int zeros);
    zeros = 0;
    flit  = '0;
    tick();
    while (ser_out !== 1'b1 && zeros < 200) begin
      zeros++;
      tick();
    end
    for (int i = 0; i < FLIT_W; i++) begin
      tick();
      flit[i] = ser_out;
    end
  endtask

  // Drives one frame onto ser_in; ej_valid must appear exactly after the last data edge.
  task automatic send_frame(input logic [FLIT_W-1:0] flit);
    check("rx_busy_before", {31'd0, ser_in_busy}, 32'd0);
    ser_in = 1'b1;
    tick();
    check("rx_busy_rise", {31'd0, ser_in_busy}, 32'd1);
    for (int i = 0; i < FLIT_W; i++) begin
      ser_in = flit[i];
      if (i == FLIT_W - 1) check("ej_valid_early", {31'd0, ej_valid}, 32'd0);
      tick();
    end
    ser_in = 1'b0;
    check("ej_valid", {31'd0, ej_valid}, 32'd1);
    check("ej_dest", {28'd0, ej_dest}, {28'd0, flit[FLIT_W-1 -: ADDR_BITS]});
    check("ej_payload", {24'd0, ej_payload}, {24'd0, flit[PAYLOAD_SIZE-1:0]});
  endtask

  task automatic consume();
    ej_ready = 1'b1;
    tick();
    ej_ready = 1'b0;
    recv_m = sat_inc(recv_m);
    check("ej_valid_drop", {31'd0, ej_valid}, 32'd0);
    check("rx_busy_drop", {31'd0, ser_in_busy}, 32'd0);
    check("recv_count", {16'd0, recv_count}, recv_m);
  endtask

  initial begin
    logic [FLIT_W-1:0] flit;
    logic [FLIT_W-1:0] got;
    logic [FLIT_W-1:0] exp;
    int zeros;
    bit stable;

    reset = 1'b1; inj_valid = 1'b0; inj_dest = '0; inj_payload = '0;
    ser_busy = 1'b0; ser_in = 1'b0; ej_ready = 1'b0;
    #12;
    check("rst_ser_out", {31'd0, ser_out}, 32'd0);
    check("rst_ej_valid", {31'd0, ej_valid}, 32'd0);
    check("rst_sent", {16'd0, sent_count}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_inj_ready", {31'd0, inj_ready}, 32'd1);

    // Single flit: start bit two edges after acceptance, then {5,A3} LSB first.
    inj_dest = 4'h5; inj_payload = 8'hA3; inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    capture_frame(got, zeros);
    check("t2_start_latency", zeros, 32'd1);
    check("t2_flit", {20'd0, got}, {20'd0, 4'h5, 8'hA3});
    tick();
    sent_m = sat_inc(sent_m);
    check("t2_sent", {16'd0, sent_count}, sent_m);

    // Fill FIFO under back-pressure, then drain.
    ser_busy = 1'b1;
    for (int k = 0; k < FIFO_DEPTH + 1; k++) begin
      flit = FLIT_W'($urandom);
      {inj_dest, inj_payload} = flit;
      inj_valid = 1'b1;
      check("t3_inj_ready", {31'd0, inj_ready}, (k < FIFO_DEPTH) ? 32'd1 : 32'd0);
      if (k < FIFO_DEPTH) exp_q.push_back(flit);
      tick();
    end
    inj_valid = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ser_out !== 1'b0) stable = 1'b0;
    end
    check("t3_busy_hold", {31'd0, stable}, 32'd1);
    ser_busy = 1'b0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      capture_frame(got, zeros);
      exp = exp_q.pop_front();
      check("t3_gap", zeros, 32'd1);
      check("t3_flit", {20'd0, got}, {20'd0, exp});
      sent_m = sat_inc(sent_m);
    end
    tick();
    check("t3_sent", {16'd0, sent_count}, sent_m);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ser_out !== 1'b0) stable = 1'b0;
    end
    check("t3_no_extra_frame", {31'd0, stable}, 32'd1);

    // Receive {2,7E}, hold ej_ready low 20 cycles with line noise, then consume.
    send_frame({4'h2, 8'h7E});
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ser_in = 1'($urandom);
      tick();
      if (ej_valid !== 1'b1 || ser_in_busy !== 1'b1 ||
          ej_dest !== 4'h2 || ej_payload !== 8'h7E) stable = 1'b0;
    end
    ser_in = 1'b0;
    check("t5_hold_stable", {31'd0, stable}, 32'd1);
    consume();

    for (int k = 0; k < 3; k++) begin
      flit = FLIT_W'($urandom);
      send_frame(flit);
      for (int i = 0; i < int'($urandom_range(0, 5)); i++) tick();
      consume();
      tick();
    end

    // Reset in the middle of both a transmit and a receive frame.
    flit = FLIT_W'($urandom);
    {inj_dest, inj_payload} = flit; inj_valid = 1'b1;
    tick();
    inj_dest = ~inj_dest;
    tick();
    inj_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    ser_in = 1'b1;
    tick();
    ser_in = 1'b1;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("t1_ser_out", {31'd0, ser_out}, 32'd0);
    check("t1_ser_in_busy", {31'd0, ser_in_busy}, 32'd0);
    check("t1_ej_valid", {31'd0, ej_valid}, 32'd0);
    check("t1_ej_fields", {20'd0, ej_dest, ej_payload}, 32'd0);
    check("t1_sent", {16'd0, sent_count}, 32'd0);
    check("t1_recv", {16'd0, recv_count}, 32'd0);
    check("t1_inj_ready", {31'd0, inj_ready}, 32'd1);
    ser_in = 1'b0;
    tick();
    reset = 1'b0;
    sent_m = 0; recv_m = 0;
    exp_q.delete();
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ser_out !== 1'b0 || ser_in_busy !== 1'b0) stable = 1'b0;
    end
    check("t1_quiet_after_reset", {31'd0, stable}, 32'd1);

    // Counter saturation from a preloaded 16'hFFFE.
    force dut.sent_count_r = 16'hFFFE;
    force dut.recv_count_r = 16'hFFFE;
    tick();
    release dut.sent_count_r;
    release dut.recv_count_r;
    sent_m = 65534; recv_m = 65534;
    tick();
    check("t6_preload", {16'd0, sent_count}, sent_m);
    for (int k = 0; k < 2; k++) begin
      flit = FLIT_W'($urandom);
      {inj_dest, inj_payload} = flit; inj_valid = 1'b1;
      tick();
      inj_valid = 1'b0;
      capture_frame(got, zeros);
      check("t6_flit", {20'd0, got}, {20'd0, flit});
      tick();
      sent_m = sat_inc(sent_m);
      check("t6_sent", {16'd0, sent_count}, sent_m);
      flit = FLIT_W'($urandom);
      send_frame(flit);
      consume();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
